// File: rtl/multi_clock_div.sv
// Bank of independent 50%-duty clock dividers sharing one reference clock.
// Each channel has a programmable half-period, a run enable, a shared phase-align strobe and a registered rising-edge tick.
module multi_clock_div #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 27,
  parameter int HALF_RST = 25_000_000
) (
  input  logic              CLK_REF,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  input  logic              SYNC,
  input  logic              WR_EN,
  input  logic [3:0]        WR_CH,
  input  logic [CNT_W-1:0]  WR_HALF,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK
);

  localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(HALF_RST);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  // Terminal count for a half-period; a programmed zero behaves as one.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] half);
    if (half == '0) begin
      return '0;
    end
    return half - ONE;
  endfunction

  logic              rst_meta_q;
  logic              rst_sync_q;
  logic              rst_sync_d;
  logic              run;

  logic [CNT_W-1:0]  half_q [NUM_CH];
  logic [CNT_W-1:0]  half_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] wr_hit;

  // Counting starts on the second edge after release: the first stage has
  // captured the release by then, and the second stage keeps it held.
  always_comb begin
    rst_sync_d = rst_meta_q;
    run        = rst_meta_q | rst_sync_q;
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = WR_EN && (WR_CH == i[3:0]);
    end
  end

  always_comb begin
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      if (wr_hit[i]) begin
        half_d[i] = WR_HALF;
      end
      if (SYNC) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (wr_hit[i]) begin
        cnt_d[i] = '0;
      end else if (run && EN[i]) begin
        if (cnt_q[i] == last_cnt(half_q[i])) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = ~clk_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK_REF or negedge RST_N) begin
    if (!RST_N) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        half_q[i] <= HALF_INIT;
        cnt_q[i]  <= '0;
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_sync_d;
      for (int i = 0; i < NUM_CH; i++) begin
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign CLK_OUT = clk_q;
  assign TICK    = tick_q;

endmodule

// File: doc/multi_clock_div.md
MULTI_CLOCK_DIV -- requirements
Module: multi_clock_div

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 27, width of each half-period register and counter.
REQ-003 Parameter HALF_RST, default 25_000_000, half-period loaded into every channel at reset.
REQ-004 CLK_REF  input  1  single reference clock; all logic on its rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 EN  input  NUM_CH  per-channel run enable; low freezes that channel.
REQ-007 SYNC  input  1  synchronous phase-align strobe for all channels.
REQ-008 WR_EN  input  1  half-period write strobe.
REQ-009 WR_CH  input  4  channel index for write.
REQ-010 WR_HALF  input  CNT_W  new half-period, in CLK_REF cycles.
REQ-011 CLK_OUT  output  NUM_CH  registered 50% duty divided clocks.
REQ-012 TICK  output  NUM_CH  registered one-cycle strobe, high in the cycle CLK_OUT[i] goes 0->1.

Function
REQ-013 Each channel i SHALL hold a half-period register HALF[i] (CNT_W bits) and counter CNT[i] (CNT_W bits).
REQ-014 Effective half-period SHALL be max(HALF[i],1); HALF[i]=0 behaves exactly as 1.
REQ-015 On each edge with EN[i]=1 and no SYNC/write to i: if CNT[i]==eff-1, CNT[i]<=0 and CLK_OUT[i] toggles; else CNT[i]<=CNT[i]+1.
REQ-016 TICK[i] SHALL be 1 for exactly the cycle following an edge where CLK_OUT[i] toggled 0->1, else 0; no tick on 1->0 toggles.
REQ-017 Output period SHALL be 2*eff CLK_REF cycles, high and low phases each eff cycles.
REQ-018 EN[i]=0 SHALL hold CNT[i] and CLK_OUT[i] and force TICK[i]=0; resumption continues from held count.
REQ-019 WR_EN=1 with WR_CH<NUM_CH SHALL load HALF[WR_CH]<=WR_HALF and CNT[WR_CH]<=0 on that edge; CLK_OUT[WR_CH] unchanged; TICK[WR_CH]=0 next cycle.
REQ-020 WR_EN=1 with WR_CH>=NUM_CH SHALL be ignored with no state change.
REQ-021 A write SHALL take effect regardless of EN[WR_CH].
REQ-022 SYNC=1 SHALL set every CNT to 0, every CLK_OUT to 0, every TICK to 0 on that edge, regardless of EN; HALF registers unchanged.
REQ-023 SYNC and WR_EN in the same cycle: write to HALF SHALL be applied and SYNC semantics apply to all channels including the written one.
REQ-024 Counter SHALL never exceed eff-1; after HALF is reduced by a write, the CNT reset of REQ-019 guarantees this.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 RST_N=0 SHALL asynchronously set CNT[i]=0, CLK_OUT=0, TICK=0, HALF[i]=HALF_RST[CNT_W-1:0] for all i.
REQ-027 Release of RST_N SHALL be synchronised internally (two-flop) so first counting edge is the second CLK_REF edge after deassertion, identically for all channels.
REQ-028 Reset asserted mid-period SHALL discard partial counts; no TICK on release.

Verification (NUM_CH=4, CNT_W=8, HALF_RST=3, EN=4'hF)
REQ-029 Reset release -> every CLK_OUT rises 3 counting edges after first counting edge, period 6 cycles, TICK=4'hF for one cycle at each rise, all channels in phase.
REQ-030 Write ch2 WR_HALF=1, then ch1 WR_HALF=0 -> both toggle every cycle from the edge after write, period 2, TICK every 2 cycles; ch0/ch3 undisturbed.
REQ-031 EN[0]=0 for 10 cycles mid-high-phase -> CLK_OUT[0] stays 1, TICK[0]=0, then completes remaining high-phase count after EN[0]=1.
REQ-032 Channels at HALF 3,5,7,1 out of phase, pulse SYNC -> next cycle CLK_OUT=4'h0, TICK=4'h0, then all restart from count 0 simultaneously.
REQ-033 WR_CH=9 WR_EN=1 -> no output or period change on any channel; SYNC+write ch3 HALF=2 same cycle -> ch3 low, then period 4.
REQ-034 RST_N low for 1 cycle mid-operation after writes -> outputs 0 immediately (asynchronously), HALF back to 3, behaviour of REQ-029 repeats.
